// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Serial MSB-first pattern transmitter with repeat and idle gaps.
//            Optional trailing even-parity bit via SEQ_PATTERN_GEN_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen #(
  parameter int       PATTERN_W  = 8,
  parameter int       LEN_W      = 4,
  parameter int       REP_W      = 4,
  parameter int       GAP_CYCLES = 2,
  parameter bit       IDLE_BIT   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pat_in,
  input  logic [LEN_W-1:0]     len_in,
  input  logic [REP_W-1:0]     rep_in,
  output logic                 outp,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int c_IW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
`endif

  state_t                 r_state, w_state_n;
  logic [PATTERN_W-1:0]   r_pat, w_pat_n;
  logic [c_IW-1:0]        r_idx, w_idx_n;
  logic [c_IW-1:0]        r_lm1, w_lm1_n;
  logic [REP_W-1:0]       r_rep, w_rep_n;
  logic [c_GW-1:0]        r_gcnt, w_gcnt_n;
  logic                   r_outp, w_outp_n;
  logic                   r_valid, w_valid_n;
  logic                   r_busy, w_busy_n;
  logic                   r_done, w_done_n;

  logic [LEN_W-1:0]       w_len_eff;
  logic [c_IW-1:0]        w_lm1_in;
  logic [REP_W-1:0]       w_rep_m1;
  logic [c_IW-1:0]        w_idx_dec;
  logic                   w_eor;

  // Out-of-range lengths fall back to the full pattern width.
  assign w_len_eff = ((len_in == '0) || (len_in > LEN_W'(PATTERN_W))) ? LEN_W'(PATTERN_W) : len_in;
  assign w_lm1_in  = c_IW'(w_len_eff - LEN_W'(1));
  assign w_rep_m1  = (rep_in == '0) ? '0 : rep_in - REP_W'(1);
  assign w_idx_dec = r_idx - c_IW'(1);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  logic w_par;
  always_comb begin
    w_par = 1'b0;
    for (int i = 0; i < PATTERN_W; i++) begin
      if (c_IW'(i) <= r_lm1) w_par = w_par ^ r_pat[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_lm1   <= '0;
      r_rep   <= '0;
      r_gcnt  <= '0;
      r_outp  <= IDLE_BIT;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_idx   <= w_idx_n;
      r_lm1   <= w_lm1_n;
      r_rep   <= w_rep_n;
      r_gcnt  <= w_gcnt_n;
      r_outp  <= w_outp_n;
      r_valid <= w_valid_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pat_n   = r_pat;
    w_idx_n   = r_idx;
    w_lm1_n   = r_lm1;
    w_rep_n   = r_rep;
    w_gcnt_n  = r_gcnt;
    w_outp_n  = r_outp;
    w_valid_n = r_valid;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_eor     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_outp_n  = IDLE_BIT;
        w_valid_n = 1'b0;
        w_busy_n  = 1'b0;
        if (start) begin
          w_pat_n   = pat_in;
          w_lm1_n   = w_lm1_in;
          w_idx_n   = w_lm1_in;
          w_rep_n   = w_rep_m1;
          w_outp_n  = pat_in[w_lm1_in];
          w_valid_n = 1'b1;
          w_busy_n  = 1'b1;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_idx != '0) begin
          w_idx_n  = w_idx_dec;
          w_outp_n = r_pat[w_idx_dec];
        end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          w_state_n = S_PARITY;
          w_outp_n  = w_par;
          w_valid_n = 1'b1;
`else
          w_eor = 1'b1;
`endif
        end
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PARITY: w_eor = 1'b1;
`endif
      S_GAP: begin
        if (r_gcnt == '0) begin
          w_state_n = S_SHIFT;
          w_idx_n   = r_lm1;
          w_outp_n  = r_pat[r_lm1];
          w_valid_n = 1'b1;
        end else begin
          w_gcnt_n = r_gcnt - c_GW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // End of one repetition: gap, seamless restart, or completion.
    if (w_eor) begin
      if (r_rep != '0) begin
        w_rep_n = r_rep - REP_W'(1);
        if (GAP_CYCLES > 0) begin
          w_state_n = S_GAP;
          w_gcnt_n  = c_GW'(GAP_CYCLES - 1);
          w_outp_n  = IDLE_BIT;
          w_valid_n = 1'b0;
        end else begin
          w_state_n = S_SHIFT;
          w_idx_n   = r_lm1;
          w_outp_n  = r_pat[r_lm1];
          w_valid_n = 1'b1;
        end
      end else begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b1;
        w_outp_n  = IDLE_BIT;
        w_valid_n = 1'b0;
      end
    end
  end

  assign outp      = r_outp;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter; the source side of the single-bit sequence detectors.
- On a start request it captures a pattern word, bit length and repeat count.
- It shifts the pattern MSB-first onto a 1-bit serial line, once per clock.
- Programmed gaps separate repetitions; the idle line level is chosen so idle never forms a zero-run.
- Drives the inp of detector blocks in directed tests and in-system self-check.

Parameters:
- PATTERN_W, 8: max pattern length in bits.
- LEN_W, 4: width of len_in; must hold the value PATTERN_W.
- REP_W, 4: width of rep_in.
- GAP_CYCLES, 2: idle cycles inserted between repetitions; 0 means back-to-back.
- IDLE_BIT, 1: level of outp whenever out_valid is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- pat_in  in  PATTERN_W  pattern; bit len-1 is sent first, bit 0 last.
- len_in  in  LEN_W  number of bits to send; 0 or >PATTERN_W is treated as PATTERN_W.
- rep_in  in  REP_W  repetitions; 0 is treated as 1.
- outp  out  1  serial data, registered.
- out_valid  out  1  high while outp carries pattern (or parity) bits.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, outp=IDLE_BIT, out_valid=0, busy=0, done=0; all counters and shift register cleared. Reset has priority over every other input.
- Reset mid-transfer aborts on the next edge: no done pulse, and outp returns to IDLE_BIT.
- States: IDLE, SHIFT, GAP; PARITY is added only with the optional feature.
- All outputs are registered.
- IDLE:
  - outp=IDLE_BIT, out_valid=0.
  - On an edge with start=1: capture pat_in, the effective length L and the effective reps R.
  - On that same edge: outp<=pat_in[L-1], out_valid<=1, busy<=1, state<=SHIFT.
  - Latency: the first bit is visible in the cycle after start is sampled.
- SHIFT:
  - Each edge presents the next lower bit; a bit index counter runs from L-1 down to 0.
  - Each bit is held on outp for exactly one cycle.
  - After bit 0 has been held, on the same edge:
    - If reps remain and GAP_CYCLES>0: state<=GAP, outp<=IDLE_BIT, out_valid<=0.
    - If reps remain and GAP_CYCLES=0: restart at bit L-1 with no bubble.
    - If this was the last rep: state<=IDLE, busy<=0, done<=1 for one cycle, outp<=IDLE_BIT, out_valid<=0.
- GAP:
  - Holds outp=IDLE_BIT, out_valid=0 for exactly GAP_CYCLES cycles.
  - On the last gap edge, loads bit L-1 and returns to SHIFT.
- Total transfer cycles, start edge to done edge: R*L + (R-1)*GAP_CYCLES.
- start while busy is ignored; pat_in, len_in and rep_in may change freely once captured.
- start in the cycle where done=1 is accepted, since state is already IDLE; this gives back-to-back transfers.
- L=1 is legal: one bit per repetition.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_PARITY_EN.
- Defined:
  - After bit 0 of every repetition, state PARITY emits one extra bit with out_valid=1.
  - That bit is the even parity (XOR) of the L bits just sent.
  - Then the block proceeds to GAP, next rep, or IDLE/done as above.
  - Total transfer cycles become R*(L+1) + (R-1)*GAP_CYCLES.
- Undefined: no PARITY state, no parity logic, timing exactly as in Behaviour.

Test Plan:
- Single pattern: pat_in=8'h00, len_in=3, rep_in=1, start for 1 cycle.
  -> outp 0,0,0 with out_valid=1 on cycles 1-3; done=1 on cycle 4 with busy=0 and outp=1. A connected 000 detector fires exactly once.
- Repeat with gap: GAP_CYCLES=2, pat_in=8'b101, len_in=3, rep_in=2.
  -> outp 1,0,1,1(idle),1(idle),1,0,1 with out_valid 1,1,1,0,0,1,1,1; done 8 cycles after start.
- Length/rep clamps: len_in=0, rep_in=0, pat_in=8'hA5.
  -> exactly 8 bits 1,0,1,0,0,1,0,1, a single repetition, done after 8 cycles.
- start held high during a transfer and pulsed again mid-shift.
  -> no restart, bit sequence unchanged; a new transfer begins only when start is high in the done cycle or later IDLE cycles.
- rst=1 during the 2nd bit of a transfer with len_in=8.
  -> next cycle: outp=1, out_valid=0, busy=0; no done pulse; a new start afterwards behaves normally.
- SEQ_PATTERN_GEN_PARITY_EN defined, pat_in=8'b110, len_in=3, rep_in=1.
  -> outp 1,1,0 then parity 0 with out_valid=1; done 4 cycles after start.
